// File: rtl/nios2_debug_pkg.sv
// rtl/nios2_debug_pkg.sv - shared types and constants for the OCI RAM arbiter
// Contents: FSM state enum, jdo field positions, request-type and grant-side encodings.
package nios2_debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_RD,
        ST_J_RD_WAIT,
        ST_J_WR,
        ST_C_RD,
        ST_C_RD_WAIT,
        ST_C_WR
    } state_e;

    // jdo layout: [34] read flag on ocimem_a, [34:3] write data, [ADDR_W+1:2] address
    localparam int JDO_RDFLAG   = 34;
    localparam int JDO_WDATA_HI = 34;
    localparam int JDO_WDATA_LO = 3;
    localparam int JDO_ADDR_LO  = 2;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_JTAG = 1'b1;

endpackage

// File: rtl/debug_rr_arb2.sv
// rtl/debug_rr_arb2.sv - two-requester round-robin arbiter (CPU vs JTAG)
// Ports: clk, rst_n (async active-low), req_cpu/req_jtag requests, grant_en
// qualifies a grant this cycle, gnt_cpu/gnt_jtag one-hot combinational grants.
import nios2_debug_pkg::*;

module debug_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_cpu,
    input  logic req_jtag,
    input  logic grant_en,
    output logic gnt_cpu,
    output logic gnt_jtag
);

    logic last_q, last_d;
    logic pick_jtag;

    always_comb begin
        // On a tie the side that did not win the previous tie goes first.
        pick_jtag = req_jtag & (~req_cpu | (last_q == GNT_CPU));
        gnt_jtag  = grant_en & pick_jtag;
        gnt_cpu   = grant_en & req_cpu & ~pick_jtag;
        // History only moves on contested grants, so an uncontested win does
        // not cost that side its turn at the next tie.
        last_d = last_q;
        if (grant_en && req_cpu && req_jtag) begin
            last_d = pick_jtag ? GNT_JTAG : GNT_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_CPU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/nios2_debug_ocimem_arbiter.sv
// rtl/nios2_debug_ocimem_arbiter.sv - sequences OCI RAM between JTAG ocimem commands and CPU Avalon slave
// Ports: clk/reset_n; JTAG strobes + jdo; Avalon avs_* slave; ram_* single-port RAM
// master (ram_rdata valid one cycle after ram_rd); MonDReg/mon_valid JTAG read
// result; jtag_overrun sticky drop flag.
import nios2_debug_pkg::*;

module nios2_debug_ocimem_arbiter #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'('hE0)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_debugaccess,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              mon_valid,
    output logic              jtag_overrun
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
    logic                pend_valid_q, pend_valid_d;
    logic                pend_type_q, pend_type_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [DATA_W-1:0]   mon_q, mon_d;
    logic                mon_valid_q, mon_valid_d;
    logic                overrun_q, overrun_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                wait_q, wait_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [3:0]          ram_be_q, ram_be_d;
    logic                ram_wr_q, ram_wr_d;
    logic                ram_rd_q, ram_rd_d;

    logic                new_req, new_type, accept;
    logic [DATA_W-1:0]   new_data, sel_data;
    logic                sel_type;
    logic [ADDR_W-1:0]   jdo_addr, jaddr_eff;
    logic                gnt_cpu, gnt_jtag;
    logic                unused_jdo;

    assign unused_jdo = ^{jdo[37:JDO_WDATA_HI+1], jdo[JDO_ADDR_LO-1:0]};

    assign jdo_addr = jdo[JDO_ADDR_LO +: ADDR_W];
    assign new_req  = (take_action_ocimem_a & jdo[JDO_RDFLAG])
                    | take_action_ocimem_b | take_no_action_ocimem_a;
    assign new_type = take_action_ocimem_b ? REQ_WR : REQ_RD;
    assign new_data = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
    // A same-cycle address load applies to the command it arrives with.
    assign jaddr_eff = take_action_ocimem_a ? jdo_addr : jaddr_q;
    // The slot holds the oldest command; a fresh strobe is granted directly
    // when the slot is empty so a JTAG read needs no extra queueing cycle.
    assign sel_type = pend_valid_q ? pend_type_q : new_type;
    assign sel_data = pend_valid_q ? pend_data_q : new_data;

    debug_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (reset_n),
        .req_cpu  (avs_read | avs_write),
        .req_jtag (pend_valid_q | new_req),
        .grant_en (state_q == ST_IDLE),
        .gnt_cpu  (gnt_cpu),
        .gnt_jtag (gnt_jtag)
    );

    assign accept = new_req & (~pend_valid_q | gnt_jtag);

    always_comb begin
        state_d      = state_q;
        jaddr_d      = jaddr_q;
        pend_valid_d = pend_valid_q;
        pend_type_d  = pend_type_q;
        pend_data_d  = pend_data_q;
        mon_d        = mon_q;
        mon_valid_d  = mon_valid_q;
        overrun_d    = overrun_q;
        rdata_d      = rdata_q;
        wait_d       = 1'b1;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_be_d     = ram_be_q;
        ram_wr_d     = 1'b0;
        ram_rd_d     = 1'b0;

        if (accept) begin
            mon_valid_d = 1'b0;
        end
        // Slot update: a granted slot is refilled by a same-cycle strobe; an
        // empty slot is filled unless the strobe itself was granted.
        if (gnt_jtag) begin
            pend_valid_d = pend_valid_q & new_req;
        end else begin
            pend_valid_d = pend_valid_q | new_req;
        end
        if (new_req && (pend_valid_q ? gnt_jtag : !gnt_jtag)) begin
            pend_type_d = new_type;
            pend_data_d = new_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_jtag) begin
                    ram_addr_d = jaddr_eff;
                    if (sel_type == REQ_RD) begin
                        state_d  = ST_J_RD;
                        ram_rd_d = 1'b1;
                    end else begin
                        state_d     = ST_J_WR;
                        ram_wr_d    = 1'b1;
                        ram_wdata_d = sel_data;
                        ram_be_d    = 4'hF;
                    end
                end else if (gnt_cpu) begin
                    ram_addr_d = avs_address;
                    if (avs_write) begin
                        state_d     = ST_C_WR;
                        wait_d      = 1'b0;
                        ram_wdata_d = avs_writedata;
                        ram_be_d    = avs_byteenable;
                        ram_wr_d    = avs_debugaccess || (avs_address < PROT_BASE);
                    end else begin
                        state_d  = ST_C_RD;
                        ram_rd_d = 1'b1;
                    end
                end
            end
            ST_J_RD:      state_d = ST_J_RD_WAIT;
            ST_J_RD_WAIT: begin
                mon_d       = ram_rdata;
                mon_valid_d = 1'b1;
                jaddr_d     = jaddr_q + ADDR_W'(1);
                state_d     = ST_IDLE;
            end
            ST_J_WR: begin
                jaddr_d = jaddr_q + ADDR_W'(1);
                state_d = ST_IDLE;
            end
            ST_C_RD: begin
                wait_d  = 1'b0;
                state_d = ST_C_RD_WAIT;
            end
            ST_C_RD_WAIT: begin
                rdata_d = ram_rdata;
                state_d = ST_IDLE;
            end
            ST_C_WR:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        // An explicit address load overrides the post-access increment.
        if (take_action_ocimem_a) begin
            jaddr_d   = jdo_addr;
            overrun_d = 1'b0;
        end
        if (new_req && !accept) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            jaddr_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= REQ_RD;
            pend_data_q  <= '0;
            mon_q        <= '0;
            mon_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rdata_q      <= '0;
            wait_q       <= 1'b1;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_be_q     <= '0;
            ram_wr_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            jaddr_q      <= jaddr_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            pend_data_q  <= pend_data_d;
            mon_q        <= mon_d;
            mon_valid_q  <= mon_valid_d;
            overrun_q    <= overrun_d;
            rdata_q      <= rdata_d;
            wait_q       <= wait_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            ram_wr_q     <= ram_wr_d;
            ram_rd_q     <= ram_rd_d;
        end
    end

    // The RAM word is only valid during C_RD_WAIT, the one cycle the CPU
    // samples; pass it straight through then and hold the captured copy after.
    assign avs_readdata    = (state_q == ST_C_RD_WAIT) ? ram_rdata : rdata_q;
    assign avs_waitrequest = wait_q;
    assign ram_addr        = ram_addr_q;
    assign ram_wdata       = ram_wdata_q;
    assign ram_be          = ram_be_q;
    assign ram_wr          = ram_wr_q;
    assign ram_rd          = ram_rd_q;
    assign MonDReg         = mon_q;
    assign mon_valid       = mon_valid_q;
    assign jtag_overrun    = overrun_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// tb/tb_nios2_debug_ocimem_arbiter.sv - scoreboard bench for the OCI RAM arbiter
module tb_nios2_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write, avs_debugaccess;
    logic [31:0] avs_writedata, avs_readdata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_wr, ram_rd;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        mon_valid, jtag_overrun;

    logic [31:0] mem [256];
    logic [31:0] mon_exp_q [$];
    logic [31:0] cpu_exp_q [$];
    logic [43:0] wr_exp_q [$];
    logic        mon_prev = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          lat;

    always #5 clk = ~clk;

    nios2_debug_ocimem_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_debugaccess         (avs_debugaccess),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_wr                  (ram_wr),
        .ram_rd                  (ram_rd),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .mon_valid               (mon_valid),
        .jtag_overrun            (jtag_overrun)
    );

    function automatic logic [31:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {4{a}};
    endfunction

    function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] addr);
        return {3'b000, rd, 24'h0, addr, 2'b00};
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected DUT activity or timeout", name);
    endtask

    // Synchronous RAM model: read data appears the cycle after ram_rd.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
            ram_rdata <= '0;
        end else begin
            if (ram_rd) ram_rdata <= mem[ram_addr];
            if (ram_wr) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Monitor: compares every DUT-presented result against the scoreboard queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mon_valid && !mon_prev) begin
                if (mon_exp_q.size() == 0) fail("mondreg_unexpected");
                else chk("mondreg", MonDReg, mon_exp_q.pop_front());
            end
            if (!avs_waitrequest && avs_read && !avs_write) begin
                if (cpu_exp_q.size() == 0) fail("cpu_rd_unexpected");
                else chk("avs_readdata", avs_readdata, cpu_exp_q.pop_front());
            end
            if (ram_wr) begin
                if (wr_exp_q.size() == 0) fail("ram_wr_unexpected");
                else chk("ram_write", {ram_addr, ram_wdata, ram_be}, wr_exp_q.pop_front());
            end
        end
        mon_prev <= mon_valid;
    end

    task automatic jcmd(input int kind, input logic [37:0] v);
        jdo = v;
        case (kind)
            0:       take_action_ocimem_a = 1'b1;
            1:       take_action_ocimem_b = 1'b1;
            default: take_no_action_ocimem_a = 1'b1;
        endcase
        @(posedge clk);
        #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    // Latency = clock edges from request cycle to the cycle waitrequest is low.
    task automatic cpu_op(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic dbg, output int l);
        avs_address = addr; avs_writedata = wd; avs_byteenable = be;
        avs_debugaccess = dbg; avs_read = !wr; avs_write = wr;
        l = 0;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            if (l >= 40) begin
                fail("cpu_timeout");
                break;
            end
            @(posedge clk);
            l++;
        end
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
        jdo = '0; avs_address = '0; avs_read = 0; avs_write = 0;
        avs_writedata = '0; avs_byteenable = '0; avs_debugaccess = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_waitreq", avs_waitrequest, 1'b1);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_mon_valid", mon_valid, 1'b0);
        chk("rst_overrun", jtag_overrun, 1'b0);
        chk("rst_ram_strobes", {ram_wr, ram_rd}, 2'b00);
        chk("rst_ram_addr", ram_addr, 8'h00);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Load address 0x10 with read: data and mon_valid three cycles on.
        mon_exp_q.push_back(32'hDEADBEEF);
        jcmd(0, jdo_a(1'b1, 8'h10));
        @(negedge clk); chk("t1_mv_cyc1", mon_valid, 1'b0);
        @(posedge clk); @(negedge clk); chk("t1_mv_cyc2", mon_valid, 1'b0);
        @(posedge clk); @(negedge clk); chk("t1_mv_cyc3", mon_valid, 1'b1);
        @(posedge clk); #1;
        // Pointer advanced to 0x11.
        mon_exp_q.push_back(32'h11111111);
        jcmd(2, '0);
        @(negedge clk); chk("t1_mv_cleared_on_accept", mon_valid, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Address 0xFF, two back-to-back writes wrap the pointer to 0x00.
        jcmd(0, jdo_a(1'b0, 8'hFF));
        wr_exp_q.push_back({8'hFF, 32'h01234567, 4'hF});
        wr_exp_q.push_back({8'h00, 32'h89ABCDEF, 4'hF});
        jcmd(1, jdo_b(32'h01234567));
        jcmd(1, jdo_b(32'h89ABCDEF));
        repeat (5) @(posedge clk);
        #1;
        chk("t2_mem_ff", mem[8'hFF], 32'h01234567);
        chk("t2_mem_00", mem[8'h00], 32'h89ABCDEF);

        // Tie with last_grant=CPU: JTAG first, CPU waits through the JTAG read.
        mon_exp_q.push_back(32'h20202020);
        cpu_exp_q.push_back(32'h40404040);
        fork
            jcmd(0, jdo_a(1'b1, 8'h20));
            cpu_op(1'b0, 8'h40, 32'h0, 4'hF, 1'b0, lat);
        join
        chk("t3_cpu_lat_after_jtag", lat, 5);
        // Next tie goes to the CPU.
        mon_exp_q.push_back(32'h21212121);
        cpu_exp_q.push_back(32'h41414141);
        fork
            jcmd(2, '0);
            cpu_op(1'b0, 8'h41, 32'h0, 4'hF, 1'b0, lat);
        join
        chk("t3_cpu_wins_next_tie", lat, 2);
        repeat (5) @(posedge clk);
        #1;

        // Protected write without debugaccess completes with no RAM write.
        cpu_op(1'b1, 8'hE4, 32'hAABBCCDD, 4'h3, 1'b0, lat);
        chk("t4_prot_wr_lat", lat, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_prot_mem", mem[8'hE4], 32'hE4E4E4E4);
        wr_exp_q.push_back({8'hE4, 32'hAABBCCDD, 4'h3});
        cpu_op(1'b1, 8'hE4, 32'hAABBCCDD, 4'h3, 1'b1, lat);
        chk("t4_dbg_wr_lat", lat, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_dbg_mem", mem[8'hE4], 32'hE4E4CCDD);

        // Two strobes while the CPU owns the RAM: second dropped.
        cpu_exp_q.push_back(32'h50505050);
        mon_exp_q.push_back(32'h22222222);
        fork
            cpu_op(1'b0, 8'h50, 32'h0, 4'hF, 1'b0, lat);
            begin
                @(posedge clk);
                #1;
                jcmd(2, '0);
                jcmd(2, '0);
            end
        join
        chk("t5_cpu_lat", lat, 2);
        @(negedge clk); chk("t5_overrun_set", jtag_overrun, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        jcmd(0, jdo_a(1'b0, 8'h30));
        @(negedge clk); chk("t5_overrun_cleared", jtag_overrun, 1'b0);
        @(posedge clk);
        #1;

        // Reset during C_RD_WAIT with a JTAG read pending.
        cpu_exp_q.push_back(32'h60606060);
        avs_address = 8'h60; avs_read = 1'b1; avs_debugaccess = 1'b0;
        @(posedge clk);
        #1;
        jcmd(2, '0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_waitreq", avs_waitrequest, 1'b1);
        chk("t6_rst_ram_rd", ram_rd, 1'b0);
        chk("t6_rst_readdata", avs_readdata, 32'h0);
        avs_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk); chk("t6_pending_lost", mon_valid, 1'b0);
        @(posedge clk);
        #1;
        cpu_exp_q.push_back(32'h61616161);
        cpu_op(1'b0, 8'h61, 32'h0, 4'hF, 1'b0, lat);
        chk("t6_idle_after_reset", lat, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("mon_queue_drained", mon_exp_q.size(), 0);
        chk("cpu_queue_drained", cpu_exp_q.size(), 0);
        chk("wr_queue_drained", wr_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
